// File: rtl/linefill_unit_pkg.sv
// linefill_unit_pkg: shared definitions for the line-fill buffer.
//   - lfb_state_e : FSM state encodings (LFB_IDLE / LFB_START / LFB_FILL)
//   - AXI_RESP_*  : AXI read response encodings
//   - lfb_log2    : ceiling log2 used to derive offset/index widths
package linefill_unit_pkg;

  typedef enum logic [1:0] {
    LFB_IDLE  = 2'b00,
    LFB_START = 2'b01,
    LFB_FILL  = 2'b10
  } lfb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Ceiling log2; an argument of 1 yields 0.
  function automatic int lfb_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/linefill_word_sel.sv
// linefill_word_sel: maps the beat counter onto a wrapped line word index
// (offset + beat, modulo the line length) and decodes it into one-hot word
// write enables.
//   offset     in  critical word index inside the line
//   beat_cnt   in  number of beats already accepted in this fill
//   beat_valid in  a beat is being accepted this cycle
//   word_we    out per-word write enable (all zero when no beat)
module linefill_word_sel
  import linefill_unit_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8
) (
  input  logic [lfb_log2(WORDS_PER_LINE)-1:0] offset,
  input  logic [lfb_log2(WORDS_PER_LINE)-1:0] beat_cnt,
  input  logic                                beat_valid,
  output logic [WORDS_PER_LINE-1:0]           word_we
);

  localparam int WOFF_W = lfb_log2(WORDS_PER_LINE);

  logic [WOFF_W-1:0] word_idx_s;

  // Line length is a power of two, so truncating the sum gives the wrap.
  assign word_idx_s = offset + beat_cnt;

  // One-hot decode of the wrapped index, gated by the beat strobe.
  always_comb begin
    word_we = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (beat_valid && (word_idx_s == WOFF_W'(i))) begin
        word_we[i] = 1'b1;
      end else begin
        word_we[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/linefill_unit.sv
// linefill_unit: line-fill buffer between the data cache controller and the
// cache-side AXI master. Issues one wrapping, critical-word-first burst per
// request, forwards the first word early and assembles the full line.
// Ports:
//   Clk, Rst (async, active low)
//   Enable/Address                request side; Busy while not idle
//   AXIStartRead/BaseAddress/AXIBurstLen  burst request to the AXI master
//   RequestAttended/Data/ReadResp/ReadLast beat stream from the AXI master
//   CriticalWord/FirstDataAcquired  early critical word
//   Line/LineReadCompleted/LineError assembled line and status
// Optional build macro LFB_FORWARD_EN adds FwdAddress/FwdHit/FwdData, a
// combinational lookup into words already received for the current line.
module linefill_unit
  import linefill_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               Enable,
  input  logic [ADDR_WIDTH-1:0]              Address,
  output logic                               Busy,
  output logic                               AXIStartRead,
  output logic [ADDR_WIDTH-1:0]              BaseAddress,
  output logic [7:0]                         AXIBurstLen,
  input  logic                               RequestAttended,
  input  logic [DATA_WIDTH-1:0]              Data,
  input  logic [1:0]                         ReadResp,
  input  logic                               ReadLast,
  output logic [DATA_WIDTH-1:0]              CriticalWord,
  output logic                               FirstDataAcquired,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] Line,
  output logic                               LineReadCompleted,
  output logic                               LineError
`ifdef LFB_FORWARD_EN
  ,
  input  logic [ADDR_WIDTH-1:0]              FwdAddress,
  output logic                               FwdHit,
  output logic [DATA_WIDTH-1:0]              FwdData
`endif
);

  localparam int WOFF_W = lfb_log2(WORDS_PER_LINE);
  localparam int BOFF_W = lfb_log2(DATA_WIDTH / 8);
  localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
  localparam logic [ADDR_WIDTH-1:0] BOFF_MASK =
    ADDR_WIDTH'((64'd1 << BOFF_W) - 64'd1);

  lfb_state_e state_q, state_d;

  logic [WOFF_W-1:0]     offset_q, offset_d;
  logic [WOFF_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] crit_q, crit_d;
  logic                  first_q, first_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic busy_s, start_s, accept_s, beat_s, last_beat_s;
  logic [WORDS_PER_LINE-1:0] word_we_s;

  assign last_beat_s = (cnt_q == WOFF_W'(WORDS_PER_LINE - 1));

  linefill_word_sel #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_word_sel (
    .offset    (offset_q),
    .beat_cnt  (cnt_q),
    .beat_valid(beat_s),
    .word_we   (word_we_s)
  );

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= LFB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; the beat counter alone decides completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LFB_IDLE: begin
        if (Enable) state_d = LFB_START;
        else        state_d = LFB_IDLE;
      end
      LFB_START: state_d = LFB_FILL;
      LFB_FILL: begin
        if (beat_s && last_beat_s) state_d = LFB_IDLE;
        else                       state_d = LFB_FILL;
      end
      default: state_d = LFB_IDLE;
    endcase
  end

  // FSM output decode: status and per-cycle strobes.
  always_comb begin
    busy_s   = (state_q != LFB_IDLE);
    start_s  = (state_q == LFB_START);
    accept_s = (state_q == LFB_IDLE) && Enable;
    beat_s   = (state_q == LFB_FILL) && RequestAttended;
  end

  // Datapath next-state: request latch, beat capture and error tracking.
  always_comb begin
    offset_d = offset_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    crit_d   = crit_q;
    first_d  = 1'b0;
    line_d   = line_q;
    done_d   = 1'b0;
    err_d    = err_q;
    if (accept_s) begin
      offset_d = Address[BOFF_W +: WOFF_W];
      base_d   = Address & ~BOFF_MASK;
      cnt_d    = '0;
      err_d    = 1'b0;
    end else if (beat_s) begin
      cnt_d = cnt_q + WOFF_W'(1);
      if (cnt_q == '0) begin
        crit_d  = Data;
        first_d = 1'b1;
      end else begin
        crit_d  = crit_q;
        first_d = 1'b0;
      end
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        if (word_we_s[i]) begin
          line_d[i*DATA_WIDTH +: DATA_WIDTH] = Data;
        end else begin
          line_d[i*DATA_WIDTH +: DATA_WIDTH] = line_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // ReadLast must be high on exactly the final beat.
      if ((ReadResp != AXI_RESP_OKAY) || (ReadLast != last_beat_s)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      done_d = last_beat_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      offset_q <= '0;
      cnt_q    <= '0;
      base_q   <= '0;
      crit_q   <= '0;
      first_q  <= 1'b0;
      line_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      crit_q   <= crit_d;
      first_q  <= first_d;
      line_q   <= line_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign Busy              = busy_s;
  assign AXIStartRead      = start_s;
  assign BaseAddress       = base_q;
  assign AXIBurstLen       = 8'(WORDS_PER_LINE - 1);
  assign CriticalWord      = crit_q;
  assign FirstDataAcquired = first_q;
  assign Line              = line_q;
  assign LineReadCompleted = done_q;
  assign LineError         = err_q;

`ifdef LFB_FORWARD_EN
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~ADDR_WIDTH'((64'd1 << (BOFF_W + WOFF_W)) - 64'd1);

  logic [WORDS_PER_LINE-1:0] valid_q, valid_d;
  logic [WOFF_W-1:0]         fwd_idx_s;

  // Per-word valid bits: cleared on a new request, set as words land.
  always_comb begin
    if (accept_s) begin
      valid_d = '0;
    end else begin
      valid_d = valid_q | word_we_s;
    end
  end

  // Valid bit register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Forwarding lookup uses registered words only, so a beat arriving this
  // cycle becomes visible one cycle later.
  always_comb begin
    fwd_idx_s = FwdAddress[BOFF_W +: WOFF_W];
    FwdHit    = 1'b0;
    FwdData   = '0;
    if ((busy_s || done_q) &&
        ((FwdAddress & LINE_MASK) == (base_q & LINE_MASK)) &&
        valid_q[fwd_idx_s]) begin
      FwdHit  = 1'b1;
      FwdData = line_q[fwd_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      FwdHit  = 1'b0;
      FwdData = '0;
    end
  end
`endif

endmodule
